// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM state, port indices and read tags.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_e;

   localparam logic P_CPU = 1'b0;
   localparam logic P_AUX = 1'b1;

   typedef struct packed {
      logic valid;
      logic port;
   } rd_tag_t;

   localparam rd_tag_t TAG_NONE = '{valid: 1'b0, port: 1'b0};

endpackage

// File: rtl/mem_arb_rdpipe.sv
// Read-tag delay line: each granted read enters as {valid, port} and emerges RD_LAT
// cycles later as a one-cycle rvalid strobe for the port that issued it.
module mem_arb_rdpipe
   import mem_arb_pkg::*;
#(
   parameter int RD_LAT = 1
) (
   input  logic    clk,
   input  logic    rst_n,
   input  rd_tag_t push_tag,
   output logic    rvalid0,
   output logic    rvalid1
);

   rd_tag_t pipe_q [RD_LAT];
   rd_tag_t pipe_d [RD_LAT];

   // Shift every tag one stage per cycle, new tag enters at stage 0.
   always_comb begin
      pipe_d[0] = push_tag;
      for (int i = 1; i < RD_LAT; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
   end

   // Tag storage; reset drops every read in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RD_LAT; i++) begin
            pipe_q[i] <= TAG_NONE;
         end
      end else begin
         for (int i = 0; i < RD_LAT; i++) begin
            pipe_q[i] <= pipe_d[i];
         end
      end
   end

   assign rvalid0 = pipe_q[RD_LAT-1].valid && (pipe_q[RD_LAT-1].port == P_CPU);
   assign rvalid1 = pipe_q[RD_LAT-1].valid && (pipe_q[RD_LAT-1].port == P_AUX);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one synchronous memory: round-robin with bounded bursts by default,
// fixed priority for port 0 when MEM_ARB_FIXED_PRIO_EN is defined.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W    = 16,
   parameter int DATA_W    = 16,
   parameter int RD_LAT    = 1,
   parameter int BURST_MAX = 8
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              req0,
   input  logic              req1,
   input  logic              wr0,
   input  logic              wr1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_data,
   input  logic [DATA_W-1:0] mem_q
);

   localparam int CNT_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX - 1);

   arb_state_e       state_q, state_d;
   logic             last_q, last_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic       own_req_s;
   logic       oth_req_s;
   logic       own_port_s;
   arb_state_e oth_state_s;
   rd_tag_t    push_tag_s;

   assign own_req_s   = (state_q == OWN1) ? req1 : req0;
   assign oth_req_s   = (state_q == OWN1) ? req0 : req1;
   assign own_port_s  = (state_q == OWN1) ? P_AUX : P_CPU;
   assign oth_state_s = (state_q == OWN1) ? OWN0 : OWN1;

   // State, fairness pointer and burst counter.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q <= IDLE;
         last_q  <= P_AUX;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef MEM_ARB_FIXED_PRIO_EN
   // Port 0 wins whenever it asks, including preemption of a port-1 tenure.
   always_comb begin
      last_d = last_q;
      cnt_d  = '0;
      if (req0) begin
         state_d = OWN0;
      end else if (req1) begin
         state_d = OWN1;
      end else begin
         state_d = IDLE;
      end
   end
`else
   // Round-robin ownership; the counter saturates so a lone owner never wraps it.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (req0 && req1) begin
               state_d = (last_q == P_CPU) ? OWN1 : OWN0;
            end else if (req0) begin
               state_d = OWN0;
            end else if (req1) begin
               state_d = OWN1;
            end else begin
               state_d = IDLE;
            end
         end
         OWN0, OWN1: begin
            if (own_req_s) begin
               if (oth_req_s && (cnt_q == CNT_MAX)) begin
                  state_d = oth_state_s;
                  cnt_d   = '0;
                  last_d  = own_port_s;
               end else begin
                  state_d = state_q;
                  cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
               end
            end else begin
               state_d = oth_req_s ? oth_state_s : IDLE;
               cnt_d   = '0;
               last_d  = own_port_s;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end
`endif

   // Grants and memory-side mux; address/data follow the owner even without a grant.
   always_comb begin
      gnt0       = 1'b0;
      gnt1       = 1'b0;
      mem_wr     = 1'b0;
      mem_addr   = addr0;
      mem_data   = wdata0;
      push_tag_s = TAG_NONE;
      case (state_q)
         OWN0: begin
            gnt0             = req0;
            mem_wr           = req0 && wr0;
            push_tag_s.valid = req0 && !wr0;
            push_tag_s.port  = P_CPU;
         end
         OWN1: begin
            gnt1             = req1;
            mem_wr           = req1 && wr1;
            mem_addr         = addr1;
            mem_data         = wdata1;
            push_tag_s.valid = req1 && !wr1;
            push_tag_s.port  = P_AUX;
         end
         default: begin
            mem_addr = addr0;
            mem_data = wdata0;
         end
      endcase
   end

   mem_arb_rdpipe #(
      .RD_LAT (RD_LAT)
   ) u_rdpipe (
      .clk      (Clock),
      .rst_n    (Resetn),
      .push_tag (push_tag_s),
      .rvalid0  (rvalid0),
      .rvalid1  (rvalid1)
   );

   assign rdata = mem_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (RD_LAT=1 and RD_LAT=2) share stimulus and are
// checked against a tenure-based ownership model and a shadow memory.
module tb_mem_arbiter;

   localparam int BM = 8;

   logic Clock = 1'b0;
   logic Resetn;
   logic req0, req1, wr0, wr1;
   logic [15:0] addr0, addr1, wdata0, wdata1;
   logic [1:0] g0_v, g1_v, rv0_v, rv1_v, wr_v;
   logic [1:0][15:0] rdata_v, maddr_v, mdata_v, mq_v;
   logic mem_clr;

   always #5 Clock = ~Clock;

   mem_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(1), .BURST_MAX(BM)) u_dut_a (
      .Clock(Clock), .Resetn(Resetn), .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(g0_v[0]), .gnt1(g1_v[0]), .rvalid0(rv0_v[0]), .rvalid1(rv1_v[0]),
      .rdata(rdata_v[0]), .mem_wr(wr_v[0]), .mem_addr(maddr_v[0]), .mem_data(mdata_v[0]),
      .mem_q(mq_v[0]));

   mem_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(2), .BURST_MAX(BM)) u_dut_b (
      .Clock(Clock), .Resetn(Resetn), .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(g0_v[1]), .gnt1(g1_v[1]), .rvalid0(rv0_v[1]), .rvalid1(rv1_v[1]),
      .rdata(rdata_v[1]), .mem_wr(wr_v[1]), .mem_addr(maddr_v[1]), .mem_data(mdata_v[1]),
      .mem_q(mq_v[1]));

   // Memory instances behind each arbiter (16 words are enough for the address range used).
   logic [15:0] mem_a [16];
   logic [15:0] mem_b [16];
   logic [15:0] qp_a [2];
   logic [15:0] qp_b [2];
   assign mq_v = {qp_b[1], qp_a[0]};

   always @(posedge Clock) begin
      for (int k = 0; k < 16; k++) begin
         if (mem_clr) mem_a[k] <= 16'h0000;
      end
      if (!mem_clr && wr_v[0]) mem_a[maddr_v[0][3:0]] <= mdata_v[0];
      qp_a[0] <= mem_a[maddr_v[0][3:0]];
      qp_a[1] <= qp_a[0];
   end

   always @(posedge Clock) begin
      for (int k = 0; k < 16; k++) begin
         if (mem_clr) mem_b[k] <= 16'h0000;
      end
      if (!mem_clr && wr_v[1]) mem_b[maddr_v[1][3:0]] <= mdata_v[1];
      qp_b[0] <= mem_b[maddr_v[1][3:0]];
      qp_b[1] <= qp_b[0];
   end

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   // Reference model: who owns the memory, how many grants it has used this tenure.
   int m_owner, m_used, m_last;
   logic [15:0] shadow [16];
   int sch_port [2][8];
   logic [15:0] sch_data [2][8];
   logic e_g0, e_g1;
   logic obs_g0, obs_g1, obs_rv0b, obs_rv1b;
   logic [15:0] obs_addr;
   int tot_g0 = 0, tot_g1 = 0, tot_wr = 0, tot_rva = 0, tot_rvb = 0, tot_rd = 0;

   task automatic model_reset();
      m_owner = -1;
      m_used  = 0;
      m_last  = 1;
      for (int d = 0; d < 2; d++)
         for (int s = 0; s < 8; s++) sch_port[d][s] = -1;
   endtask

   task automatic model_advance();
`ifdef MEM_ARB_FIXED_PRIO_EN
      m_owner = req0 ? 0 : (req1 ? 1 : -1);
`else
      bit own, oth;
      if (m_owner < 0) begin
         if (req0 && req1) m_owner = (m_last == 0) ? 1 : 0;
         else if (req0)    m_owner = 0;
         else if (req1)    m_owner = 1;
         m_used = 0;
      end else begin
         own = (m_owner == 0) ? req0 : req1;
         oth = (m_owner == 0) ? req1 : req0;
         if (own) begin
            m_used++;
            if (oth && m_used >= BM) begin
               m_last  = m_owner;
               m_owner = 1 - m_owner;
               m_used  = 0;
            end
         end else begin
            m_last  = m_owner;
            m_owner = oth ? 1 - m_owner : -1;
            m_used  = 0;
         end
      end
`endif
   endtask

   // One clock cycle: compare both DUTs against the model, then advance at the rising edge.
   task automatic step();
      logic e_wr, e_w, rd0, rd1;
      logic [15:0] e_addr, e_data;
      int slot, ep, p;
      #1;
      if (!Resetn) begin
         model_reset();
         e_g0 = 1'b0;
         e_g1 = 1'b0;
      end else begin
         e_g0 = (m_owner == 0) && req0;
         e_g1 = (m_owner == 1) && req1;
      end
      e_wr   = (e_g0 && wr0) || (e_g1 && wr1);
      e_addr = (m_owner == 1) ? addr1 : addr0;
      e_data = (m_owner == 1) ? wdata1 : wdata0;
      slot   = cyc % 8;
      for (int d = 0; d < 2; d++) begin
         n_cmp++;
         if ({g0_v[d], g1_v[d], wr_v[d]} !== {e_g0, e_g1, e_wr}) begin
            n_bad++;
            $display("FAIL ctl dut%0d cyc %0d: gnt0,gnt1,mem_wr=%b%b%b required %b%b%b",
                     d, cyc, g0_v[d], g1_v[d], wr_v[d], e_g0, e_g1, e_wr);
         end
         n_cmp++;
         if ({maddr_v[d], mdata_v[d]} !== {e_addr, e_data}) begin
            n_bad++;
            $display("FAIL mux dut%0d cyc %0d: addr/data=%h/%h required %h/%h",
                     d, cyc, maddr_v[d], mdata_v[d], e_addr, e_data);
         end
         ep  = sch_port[d][slot];
         rd0 = (ep == 0);
         rd1 = (ep == 1);
         n_cmp++;
         if ({rv0_v[d], rv1_v[d]} !== {rd0, rd1}) begin
            n_bad++;
            $display("FAIL rvalid dut%0d cyc %0d: rvalid0,1=%b%b required %b%b",
                     d, cyc, rv0_v[d], rv1_v[d], rd0, rd1);
         end
         if (ep >= 0) begin
            n_cmp++;
            if (rdata_v[d] !== sch_data[d][slot]) begin
               n_bad++;
               $display("FAIL rdata dut%0d cyc %0d: rdata=%h required %h",
                        d, cyc, rdata_v[d], sch_data[d][slot]);
            end
         end
         sch_port[d][slot] = -1;
      end
      obs_g0   = g0_v[0];
      obs_g1   = g1_v[0];
      obs_addr = maddr_v[0];
      obs_rv0b = rv0_v[1];
      obs_rv1b = rv1_v[1];
      tot_g0  += int'(g0_v[0]);
      tot_g1  += int'(g1_v[0]);
      tot_wr  += int'(wr_v[0]);
      tot_rva += int'(rv0_v[0] | rv1_v[0]);
      tot_rvb += int'(rv0_v[1] | rv1_v[1]);
      if (e_g0 || e_g1) begin
         p   = e_g1 ? 1 : 0;
         e_w = e_g1 ? wr1 : wr0;
         if (e_w) begin
            shadow[e_addr[3:0]] = e_data;
         end else begin
            tot_rd++;
            for (int d = 0; d < 2; d++) begin
               sch_port[d][(cyc + d + 1) % 8] = p;
               sch_data[d][(cyc + d + 1) % 8] = shadow[e_addr[3:0]];
            end
         end
      end
      @(posedge Clock);
      cyc++;
      if (!Resetn) model_reset();
      else model_advance();
      @(negedge Clock);
   endtask

   task automatic wait_gnt(input int p);
      bit done = 1'b0;
      for (int i = 0; i < 24 && !done; i++) begin
         step();
         done = (p == 0) ? e_g0 : e_g1;
      end
      n_cmp++;
      if (!done) begin
         n_bad++;
         $display("FAIL wait_gnt port %0d: no grant within 24 cycles, required one", p);
      end
   endtask

   task automatic new_req(input int p);
      if (p == 0) begin
         wr0 = 1'($urandom_range(0, 1)); addr0 = 16'($urandom_range(0, 15)); wdata0 = 16'($urandom);
      end else begin
         wr1 = 1'($urandom_range(0, 1)); addr1 = 16'($urandom_range(0, 15)); wdata1 = 16'($urandom);
      end
   endtask

   task automatic idle(input int n);
      req0 = 1'b0;
      req1 = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic test_reset();
      Resetn = 1'b0; mem_clr = 1'b1; req0 = 1'b1; wr0 = 1'b0; addr0 = 16'h0003;
      #1;
      n_cmp++;
      if ({g0_v, g1_v, rv0_v, rv1_v, wr_v} !== 10'b0) begin
         n_bad++;
         $display("FAIL reset_outputs: %b required all zero", {g0_v, g1_v, rv0_v, rv1_v, wr_v});
      end
      step(); step();
      Resetn = 1'b1; mem_clr = 1'b0;
      step();
      n_cmp++;
      if (obs_g0 !== 1'b0) begin
         n_bad++; $display("FAIL reset_first_cycle: gnt0=%b required 0", obs_g0);
      end
      step();
      n_cmp++;
      if (obs_g0 !== 1'b1 || obs_addr !== 16'h0003) begin
         n_bad++; $display("FAIL reset_second_cycle: gnt0=%b addr=%h required 1/0003", obs_g0, obs_addr);
      end
      idle(2);
   endtask

   task automatic test_write_read();
      int wr_base = tot_wr;
      req0 = 1'b1; wr0 = 1'b1; addr0 = 16'h0005; wdata0 = 16'h00AB;
      wait_gnt(0);
      req0 = 1'b0; wr0 = 1'b0;
      req1 = 1'b1; wr1 = 1'b0; addr1 = 16'h0005;
      wait_gnt(1);
      req1 = 1'b0;
      #1;
      n_cmp++;
      if (rv1_v[0] !== 1'b1 || rv0_v[0] !== 1'b0 || rdata_v[0] !== 16'h00AB) begin
         n_bad++;
         $display("FAIL wr_rd: rvalid1=%b rvalid0=%b rdata=%h required 1/0/00ab", rv1_v[0], rv0_v[0], rdata_v[0]);
      end
      idle(3);
      n_cmp++;
      if (tot_wr - wr_base !== 1) begin
         n_bad++; $display("FAIL wr_rd_count: mem_wr cycles=%0d required 1", tot_wr - wr_base);
      end
   endtask

   task automatic test_burst();
      int b0, b1;
      new_req(0); new_req(1);
      req0 = 1'b1; req1 = 1'b1;
      step();
      for (int w = 0; w < 2; w++) begin
         b0 = tot_g0; b1 = tot_g1;
         for (int i = 0; i < 16; i++) begin
            step();
            if (e_g0) new_req(0);
            if (e_g1) new_req(1);
         end
`ifndef MEM_ARB_FIXED_PRIO_EN
         n_cmp++;
         if (tot_g0 - b0 !== BM || tot_g1 - b1 !== BM) begin
            n_bad++;
            $display("FAIL burst_window %0d: grants %0d/%0d required %0d/%0d", w, tot_g0 - b0, tot_g1 - b1, BM, BM);
         end
`endif
      end
      idle(4);
   endtask

   task automatic test_same_cycle();
      Resetn = 1'b0;
      step();
      Resetn = 1'b1;
      req0 = 1'b1; req1 = 1'b1; wr0 = 1'b0; wr1 = 1'b0;
      step();
      step();
      n_cmp++;
      if (obs_g0 !== 1'b1 || obs_g1 !== 1'b0) begin
         n_bad++; $display("FAIL same_cycle: gnt0/gnt1=%b%b required 10", obs_g0, obs_g1);
      end
      idle(3);
   endtask

   task automatic test_handover();
      bit prev_rv0 = 1'b0, found = 1'b0;
      wr0 = 1'b0; wr1 = 1'b0;
      addr0 = 16'($urandom_range(0, 7)); addr1 = 16'($urandom_range(8, 15));
      req0 = 1'b1; req1 = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (prev_rv0 && obs_rv1b) found = 1'b1;
         prev_rv0 = obs_rv0b;
      end
      idle(4);
`ifndef MEM_ARB_FIXED_PRIO_EN
      n_cmp++;
      if (!found) begin
         n_bad++; $display("FAIL handover: rvalid0 then rvalid1 seen=%b required 1", found);
      end
`endif
   endtask

   task automatic test_reset_mid_read();
      int rva, rvb;
      req1 = 1'b1; wr1 = 1'b0; addr1 = 16'h0005;
      wait_gnt(1);
      req1 = 1'b0;
      rva = tot_rva; rvb = tot_rvb;
      Resetn = 1'b0;
      step();
      Resetn = 1'b1;
      req0 = 1'b1; wr0 = 1'b0; addr0 = 16'h0007;
      step();
      step();
      n_cmp++;
      if (obs_g0 !== 1'b1) begin
         n_bad++; $display("FAIL reset_mid_read_idle: gnt0=%b required 1 on second cycle", obs_g0);
      end
      req0 = 1'b0;
      for (int i = 0; i < 3; i++) step();
      n_cmp++;
      if (tot_rva - rva !== 1 || tot_rvb - rvb !== 1) begin
         n_bad++;
         $display("FAIL reset_mid_read_rvalid: strobes %0d/%0d required 1/1 (port0 read only)", tot_rva - rva, tot_rvb - rvb);
      end
   endtask

   task automatic test_random();
      bit pend0 = 1'b0, pend1 = 1'b0;
      int rd_base = tot_rd, rv_base = tot_rva;
      for (int i = 0; i < 400; i++) begin
         if (!pend0 && $urandom_range(0, 3) != 0) begin pend0 = 1'b1; new_req(0); end
         if (!pend1 && $urandom_range(0, 3) != 0) begin pend1 = 1'b1; new_req(1); end
         req0 = pend0; req1 = pend1;
         step();
         if (e_g0) pend0 = 1'b0;
         if (e_g1) pend1 = 1'b0;
      end
      idle(4);
      n_cmp++;
      if (tot_rva - rv_base !== tot_rd - rd_base) begin
         n_bad++;
         $display("FAIL random_reads: rvalid strobes %0d required %0d", tot_rva - rv_base, tot_rd - rd_base);
      end
   endtask

   initial begin
      req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
      addr0 = 16'h0000; addr1 = 16'h0000; wdata0 = 16'h0000; wdata1 = 16'h0000;
      Resetn = 1'b0; mem_clr = 1'b1;
      for (int k = 0; k < 16; k++) shadow[k] = 16'h0000;
      model_reset();
      @(negedge Clock);
      test_reset();
      test_write_read();
      test_burst();
      test_same_cycle();
      test_handover();
      test_reset_mid_read();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish within 200000 time units");
      $fatal(1);
   end

endmodule
